// File: rtl/mask_cfg_pkg.sv
// Shared constants for the luma mask configuration scheduler: register map,
// reset defaults, auto-threshold FSM encoding and the configuration set layout.
package mask_cfg_pkg;

  localparam int unsigned DEF_X1        = 55;
  localparam int unsigned DEF_Y1        = 60;
  localparam int unsigned DEF_X2        = 660;
  localparam int unsigned DEF_Y2        = 192;
  localparam int unsigned DEF_THR       = 64;
  localparam int unsigned DEF_BLOBX     = 21;
  localparam int unsigned DEF_BLOBY     = 15;
  localparam int unsigned DEF_AUTO_LOG2 = 12;
  localparam int unsigned DEF_Y_OFFSET  = 24;

  localparam logic [2:0] ADDR_X1    = 3'd0;
  localparam logic [2:0] ADDR_Y1    = 3'd1;
  localparam logic [2:0] ADDR_X2    = 3'd2;
  localparam logic [2:0] ADDR_Y2    = 3'd3;
  localparam logic [2:0] ADDR_THR   = 3'd4;
  localparam logic [2:0] ADDR_BLOBX = 3'd5;
  localparam logic [2:0] ADDR_BLOBY = 3'd6;
  localparam logic [2:0] ADDR_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CALC  = 2'd2,
    WAIT  = 2'd3
  } auto_state_e;

  typedef struct packed {
    logic [9:0] x1;
    logic [9:0] y1;
    logic [9:0] x2;
    logic [9:0] y2;
    logic [7:0] thr;
    logic [8:0] blob_x;
    logic [8:0] blob_y;
  } cfg_set_t;

endpackage

// File: rtl/mask_cfg_ctrl_luma_mean_acc.sv
// ROI-gated luma accumulator: sums the first 2^AUTO_LOG2 in-window pixels of a
// frame and exposes the resulting mean once the sample set is complete.
module luma_mean_acc #(
  parameter int unsigned AUTO_LOG2 = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       acc_en,
  input  logic       pix_valid,
  input  logic [9:0] tv_x,
  input  logic [9:0] tv_y,
  input  logic [7:0] pix_y,
  input  logic [9:0] x_min,
  input  logic [9:0] x_max,
  input  logic [9:0] y_min,
  input  logic [9:0] y_max,
  output logic       done,
  output logic [7:0] mean
);

  localparam int unsigned SUM_W = 8 + AUTO_LOG2;

  logic [SUM_W-1:0]   sum;
  logic [AUTO_LOG2:0] count;
  logic               in_roi;
  logic               take;

  assign in_roi = (tv_x >= x_min) && (tv_x <= x_max) && (tv_y >= y_min) && (tv_y <= y_max);
  assign done   = count[AUTO_LOG2];
  assign take   = acc_en && pix_valid && in_roi && !done;
  // Top byte of the sum is the mean once exactly 2^AUTO_LOG2 samples are in.
  assign mean   = sum[SUM_W-1 -: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= '0;
      count <= '0;
    end else if (clr) begin
      sum   <= '0;
      count <= '0;
    end else if (take) begin
      sum   <= sum + SUM_W'(pix_y);
      count <= count + (AUTO_LOG2+1)'(1);
    end
  end

endmodule

// File: rtl/mask_cfg_ctrl.sv
// Configuration scheduler for the luma mask stage: host shadow registers applied
// atomically at frame start, plus an optional per-frame auto threshold.
module mask_cfg_ctrl
  import mask_cfg_pkg::*;
#(
  parameter int unsigned X1_DEF    = DEF_X1,
  parameter int unsigned Y1_DEF    = DEF_Y1,
  parameter int unsigned X2_DEF    = DEF_X2,
  parameter int unsigned Y2_DEF    = DEF_Y2,
  parameter int unsigned THR_DEF   = DEF_THR,
  parameter int unsigned BLOBX_DEF = DEF_BLOBX,
  parameter int unsigned BLOBY_DEF = DEF_BLOBY,
  parameter int unsigned AUTO_LOG2 = DEF_AUTO_LOG2,
  parameter int unsigned Y_OFFSET  = DEF_Y_OFFSET
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] tv_x,
  input  logic [9:0] tv_y,
  input  logic [7:0] Y,
  input  logic       auto_en,
  input  logic       cfg_we,
  input  logic [2:0] cfg_addr,
  input  logic [9:0] cfg_wdata,
  output logic [9:0] x_min,
  output logic [9:0] x_max,
  output logic [9:0] y_min,
  output logic [9:0] y_max,
  output logic [7:0] y_thr,
  output logic [8:0] blob_min_x,
  output logic [8:0] blob_min_y,
  output logic       cfg_applied,
  output logic       cfg_err,
  output logic       thr_valid
);

  localparam cfg_set_t DEF_SET = '{
    x1:     10'(X1_DEF),
    y1:     10'(Y1_DEF),
    x2:     10'(X2_DEF),
    y2:     10'(Y2_DEF),
    thr:    8'(THR_DEF),
    blob_x: 9'(BLOBX_DEF),
    blob_y: 9'(BLOBY_DEF)
  };

  // Auto threshold sits Y_OFFSET below the mean, floored at 1 so the mask never goes dead.
  function automatic logic [7:0] calc_auto_thr(input logic [7:0] mean);
    if (mean > 8'(Y_OFFSET))
      return mean - 8'(Y_OFFSET);
    else
      return 8'd1;
  endfunction

  cfg_set_t    shadow;
  cfg_set_t    active;
  logic        pending;
  logic        auto_en_q;
  logic        wr_hit;
  logic        roi_ok;

  auto_state_e state;
  auto_state_e state_nx;
  logic        calc_ld;
  logic        publish;
  logic        acc_en;
  logic        acc_done;
  logic [7:0]  acc_mean;
  logic [7:0]  auto_thr;
  logic [7:0]  auto_thr_pend;

  assign wr_hit = cfg_we && (cfg_addr != ADDR_RSVD);
  assign roi_ok = (shadow.x1 <= shadow.x2) && (shadow.y1 <= shadow.y2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= DEF_SET;
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_X1:    shadow.x1     <= cfg_wdata;
        ADDR_Y1:    shadow.y1     <= cfg_wdata;
        ADDR_X2:    shadow.x2     <= cfg_wdata;
        ADDR_Y2:    shadow.y2     <= cfg_wdata;
        ADDR_THR:   shadow.thr    <= cfg_wdata[7:0];
        ADDR_BLOBX: shadow.blob_x <= cfg_wdata[8:0];
        ADDR_BLOBY: shadow.blob_y <= cfg_wdata[8:0];
        default:    ;
      endcase
    end
  end

  // Apply uses the shadow as it stood before this cycle's write, so a write
  // landing on frame_start keeps pending set for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= DEF_SET;
      pending     <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_err     <= 1'b0;
      auto_en_q   <= 1'b0;
    end else begin
      cfg_applied <= 1'b0;
      if (frame_start) begin
        auto_en_q <= auto_en;
        if (pending) begin
          if (roi_ok) begin
            active      <= shadow;
            cfg_applied <= 1'b1;
            cfg_err     <= 1'b0;
          end else begin
            cfg_err     <= 1'b1;
          end
        end
      end
      if (wr_hit)
        pending <= 1'b1;
      else if (frame_start)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (frame_start && auto_en) state_nx = ACCUM;
      ACCUM:   if (!frame_start && acc_done) state_nx = CALC;
      CALC:    state_nx = WAIT;
      WAIT:    if (frame_start) state_nx = auto_en ? ACCUM : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    acc_en  = (state == ACCUM);
    calc_ld = (state == CALC);
    publish = (state == WAIT) && frame_start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_thr_pend <= '0;
      auto_thr      <= '0;
      thr_valid     <= 1'b0;
    end else begin
      if (calc_ld)
        auto_thr_pend <= calc_auto_thr(acc_mean);
      if (publish) begin
        auto_thr  <= auto_thr_pend;
        thr_valid <= auto_en;
      end
    end
  end

  // Counters clear on every frame_start so each frame starts a fresh sample set.
  luma_mean_acc #(
    .AUTO_LOG2 (AUTO_LOG2)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (frame_start),
    .acc_en    (acc_en),
    .pix_valid (pix_valid),
    .tv_x      (tv_x),
    .tv_y      (tv_y),
    .pix_y     (Y),
    .x_min     (active.x1),
    .x_max     (active.x2),
    .y_min     (active.y1),
    .y_max     (active.y2),
    .done      (acc_done),
    .mean      (acc_mean)
  );

  assign x_min      = active.x1;
  assign x_max      = active.x2;
  assign y_min      = active.y1;
  assign y_max      = active.y2;
  assign blob_min_x = active.blob_x;
  assign blob_min_y = active.blob_y;
  assign y_thr      = (auto_en_q && thr_valid) ? auto_thr : active.thr;

endmodule
